// File: rtl/led_sequencer.sv
// Parametrised LED pattern engine: a programmable rate divider that steps a
// WIDTH-bit LED bus through count-up, count-down, walk, bounce, gray or hold.
module led_sequencer #(
   parameter int WIDTH         = 8,
   parameter int CLK_HZ        = 50000000,
   parameter int COUNTER_WIDTH = 32,
   parameter int SEL_WIDTH     = 4
) (
   input  logic                 CLK50MHZ,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [SEL_WIDTH-1:0] rate_sel,
   input  logic [2:0]           mode,
   output logic                 tick_o,
   output logic [WIDTH-1:0]     led_o
);

   typedef enum logic {
      DIR_LEFT,
      DIR_RIGHT
   } dir_t;

   localparam logic [COUNTER_WIDTH-1:0] CLK_DIV = COUNTER_WIDTH'(CLK_HZ);
   localparam logic [COUNTER_WIDTH-1:0] ONE     = COUNTER_WIDTH'(1);

   logic [COUNTER_WIDTH-1:0] cnt, cnt_n;
   logic [COUNTER_WIDTH-1:0] div_shift, div_eff;
   logic [WIDTH-1:0]         step, step_n, step_inc, led_n;
   logic [2:0]               mode_q, mode_q_n;
   dir_t                     dir, dir_n;
   logic                     tick_n;

   // Clamp to 1 so that large shifts still give a tick every cycle.
   always_comb begin
      div_shift = CLK_DIV >> rate_sel;
      div_eff   = (div_shift == '0) ? ONE : div_shift;
   end

   always_ff @(posedge CLK50MHZ) begin
      if (reset) begin
         cnt    <= '0;
         step   <= '0;
         mode_q <= 3'd0;
         dir    <= DIR_LEFT;
         tick_o <= 1'b0;
         led_o  <= '0;
      end else begin
         cnt    <= cnt_n;
         step   <= step_n;
         mode_q <= mode_q_n;
         dir    <= dir_n;
         tick_o <= tick_n;
         led_o  <= led_n;
      end
   end

   // A mode change restarts the pattern and the divider and suppresses the
   // step on that edge; otherwise the divider runs only while enabled.
   always_comb begin
      cnt_n    = cnt;
      step_n   = step;
      mode_q_n = mode_q;
      dir_n    = dir;
      tick_n   = 1'b0;
      led_n    = led_o;
      step_inc = step + WIDTH'(1);

      if (mode != mode_q) begin
         mode_q_n = mode;
         cnt_n    = '0;
         step_n   = '0;
         dir_n    = DIR_LEFT;
         case (mode)
            3'd0, 3'd1, 3'd4: led_n = '0;
            3'd2, 3'd3:       led_n = WIDTH'(1);
            default:          led_n = led_o;
         endcase
      end else if (enable) begin
         if (cnt >= div_eff - ONE) begin
            cnt_n  = '0;
            tick_n = 1'b1;
            case (mode_q)
               3'd0: led_n = led_o + WIDTH'(1);
               3'd1: led_n = led_o - WIDTH'(1);
               3'd2: led_n = {led_o[WIDTH-2:0], led_o[WIDTH-1]};
               // Turning at an end moves straight to the neighbour bit.
               3'd3: begin
                  if (dir == DIR_LEFT) begin
                     if (led_o[WIDTH-1]) begin
                        dir_n = DIR_RIGHT;
                        led_n = led_o >> 1;
                     end else begin
                        led_n = led_o << 1;
                     end
                  end else begin
                     if (led_o[0]) begin
                        dir_n = DIR_LEFT;
                        led_n = led_o << 1;
                     end else begin
                        led_n = led_o >> 1;
                     end
                  end
               end
               3'd4: begin
                  step_n = step_inc;
                  led_n  = step_inc ^ (step_inc >> 1);
               end
               default: led_n = led_o;
            endcase
         end else begin
            cnt_n = cnt + ONE;
         end
      end
   end

endmodule

// File: tb/tb_led_sequencer.sv
// Self-checking bench for led_sequencer: directed pattern scenarios plus a
// randomized run, all compared against a closed-form behavioural model.
module tb_led_sequencer;

   localparam int W  = 4;
   localparam int HZ = 16;
   localparam int CW = 8;
   localparam int SW = 4;

   logic          CLK50MHZ = 1'b0;
   logic          reset    = 1'b1;
   logic          enable   = 1'b0;
   logic [SW-1:0] rate_sel = '0;
   logic [2:0]    mode     = 3'd0;
   logic          tick_o;
   logic [W-1:0]  led_o;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: active mode, divider count, ticks since the
   // last mode change, and the expected registered outputs.
   int           m_mode = 0;
   int           m_cnt  = 0;
   int           m_n    = 0;
   logic         m_tick = 1'b0;
   logic [W-1:0] m_led  = '0;

   led_sequencer #(
      .WIDTH(W), .CLK_HZ(HZ), .COUNTER_WIDTH(CW), .SEL_WIDTH(SW)
   ) dut (
      .CLK50MHZ(CLK50MHZ), .reset(reset), .enable(enable),
      .rate_sel(rate_sel), .mode(mode), .tick_o(tick_o), .led_o(led_o)
   );

   always #5 CLK50MHZ = ~CLK50MHZ;

   // LED value after n steps of a pattern, starting from its initial value.
   function automatic int pattern(int md, int n);
      int span;
      int p;
      int k;
      span = 1 << W;
      case (md)
         0: return n % span;
         1: return (span - (n % span)) % span;
         2: return 1 << (n % W);
         3: begin
            p = n % (2 * (W - 1));
            return 1 << ((p <= W - 1) ? p : 2 * (W - 1) - p);
         end
         4: begin
            k = n % span;
            return k ^ (k >> 1);
         end
         default: return 0;
      endcase
   endfunction

   function automatic int div_of(int rs);
      int d;
      d = HZ >> rs;
      return (d < 1) ? 1 : d;
   endfunction

   task automatic tick_clock();
      @(posedge CLK50MHZ);
      m_tick = 1'b0;
      if (reset) begin
         m_mode = 0;
         m_cnt  = 0;
         m_n    = 0;
         m_led  = '0;
      end else if (int'(mode) != m_mode) begin
         m_mode = int'(mode);
         m_cnt  = 0;
         m_n    = 0;
         if (m_mode <= 4) m_led = W'(pattern(m_mode, 0));
      end else if (enable) begin
         if (m_cnt >= div_of(int'(rate_sel)) - 1) begin
            m_cnt  = 0;
            m_tick = 1'b1;
            m_n++;
            if (m_mode <= 4) m_led = W'(pattern(m_mode, m_n));
         end else begin
            m_cnt++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; mode = 3'd0; rate_sel = '0; enable = 1'b1;
      for (int i = 0; i < 3; i++) tick_clock();
      n_checks++;
      if (led_o !== '0 || tick_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_state led=%0d tick=%0b required led=0 tick=0", led_o, tick_o);
      end
   endtask

   task automatic test_up_count();
      int ticks = 0;
      int last  = 0;
      reset = 1'b0; mode = 3'd0; rate_sel = '0; enable = 1'b1;
      for (int cyc = 1; cyc <= 300 && ticks < 16; cyc++) begin
         tick_clock();
         n_checks++;
         if (led_o !== m_led || tick_o !== m_tick) begin
            n_fail++;
            $display("[TB] FAIL up_model cyc=%0d led=%0d tick=%0b required led=%0d tick=%0b", cyc, led_o, tick_o, m_led, m_tick);
         end
         if (tick_o === 1'b1) begin
            ticks++;
            n_checks++;
            if (led_o !== W'(ticks % 16)) begin
               n_fail++;
               $display("[TB] FAIL up_value tick=%0d led=%0d required %0d", ticks, led_o, ticks % 16);
            end
            n_checks++;
            if (cyc - last != 16) begin
               n_fail++;
               $display("[TB] FAIL up_period got %0d cycles required 16", cyc - last);
            end
            last = cyc;
         end
      end
      n_checks++;
      if (ticks != 16) begin
         n_fail++;
         $display("[TB] FAIL up_ticks got %0d required 16", ticks);
      end
   endtask

   task automatic test_down_rate();
      int exp_seq[3] = '{15, 14, 13};
      int ticks = 0;
      int last  = 0;
      mode = 3'd1; rate_sel = 4'd2;
      tick_clock();
      n_checks++;
      if (led_o !== 4'd0 || tick_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL down_init led=%0d tick=%0b required led=0 tick=0", led_o, tick_o);
      end
      for (int cyc = 1; cyc <= 40 && ticks < 3; cyc++) begin
         tick_clock();
         if (tick_o === 1'b1) begin
            n_checks++;
            if (led_o !== W'(exp_seq[ticks]) || cyc - last != 4) begin
               n_fail++;
               $display("[TB] FAIL down_step led=%0d after %0d cycles required led=%0d after 4", led_o, cyc - last, exp_seq[ticks]);
            end
            ticks++;
            last = cyc;
         end
      end
      n_checks++;
      if (ticks != 3) begin
         n_fail++;
         $display("[TB] FAIL down_ticks got %0d required 3", ticks);
      end
   endtask

   task automatic test_walk_bounce();
      int exp_walk[4]   = '{2, 4, 8, 1};
      int exp_bounce[7] = '{2, 4, 8, 4, 2, 1, 2};
      mode = 3'd2; rate_sel = 4'd4;
      tick_clock();
      n_checks++;
      if (led_o !== 4'd1 || tick_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL walk_init led=%0d tick=%0b required led=1 tick=0", led_o, tick_o);
      end
      for (int i = 0; i < 4; i++) begin
         tick_clock();
         n_checks++;
         if (led_o !== W'(exp_walk[i]) || tick_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL walk_step%0d led=%0d tick=%0b required led=%0d tick=1", i, led_o, tick_o, exp_walk[i]);
         end
      end
      mode = 3'd3;
      tick_clock();
      n_checks++;
      if (led_o !== 4'd1 || tick_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL bounce_init led=%0d tick=%0b required led=1 tick=0", led_o, tick_o);
      end
      for (int i = 0; i < 7; i++) begin
         tick_clock();
         n_checks++;
         if (led_o !== W'(exp_bounce[i]) || tick_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bounce_step%0d led=%0d tick=%0b required led=%0d tick=1", i, led_o, tick_o, exp_bounce[i]);
         end
      end
   endtask

   task automatic test_gray();
      int exp_seq[8] = '{1, 3, 2, 6, 7, 5, 4, 12};
      int ticks = 0;
      int last  = 0;
      mode = 3'd4; rate_sel = 4'd3;
      for (int cyc = 0; cyc <= 40 && ticks < 8; cyc++) begin
         tick_clock();
         if (tick_o === 1'b1) begin
            n_checks++;
            if (led_o !== W'(exp_seq[ticks]) || cyc - last != 2) begin
               n_fail++;
               $display("[TB] FAIL gray_step%0d led=%0d after %0d cycles required led=%0d after 2", ticks, led_o, cyc - last, exp_seq[ticks]);
            end
            ticks++;
            last = cyc;
         end
      end
      n_checks++;
      if (ticks != 8) begin
         n_fail++;
         $display("[TB] FAIL gray_ticks got %0d required 8", ticks);
      end
   endtask

   task automatic test_pause_rate();
      logic [W-1:0] held;
      int wait_cyc;
      int prev;
      mode = 3'd0; rate_sel = '0; enable = 1'b1;
      for (int i = 0; i < 40 && !(m_mode == 0 && m_cnt == 9); i++) tick_clock();
      held   = led_o;
      enable = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick_clock();
         n_checks++;
         if (led_o !== held || tick_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL pause_hold led=%0d tick=%0b required led=%0d tick=0", led_o, tick_o, held);
         end
      end
      enable   = 1'b1;
      wait_cyc = 0;
      for (int i = 1; i <= 40 && wait_cyc == 0; i++) begin
         tick_clock();
         if (tick_o === 1'b1) wait_cyc = i;
      end
      n_checks++;
      if (wait_cyc != 16 - 9 || led_o !== held + W'(1)) begin
         n_fail++;
         $display("[TB] FAIL resume_tick after %0d cycles led=%0d required after %0d led=%0d", wait_cyc, led_o, 16 - 9, held + W'(1));
      end
      for (int i = 0; i < 40 && m_cnt != 10; i++) tick_clock();
      rate_sel = 4'd2;
      tick_clock();
      n_checks++;
      if (tick_o !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL rate_drop_tick tick=%0b required 1", tick_o);
      end
      for (int k = 0; k < 2; k++) begin
         prev = 0;
         for (int i = 1; i <= 20 && prev == 0; i++) begin
            tick_clock();
            if (tick_o === 1'b1) prev = i;
         end
         n_checks++;
         if (prev != 4) begin
            n_fail++;
            $display("[TB] FAIL rate_period got %0d cycles required 4", prev);
         end
      end
   endtask

   task automatic test_reset_hold();
      mode = 3'd0; rate_sel = 4'd4; enable = 1'b1;
      for (int i = 0; i < 3; i++) tick_clock();
      reset = 1'b1;
      tick_clock();
      reset = 1'b0;
      n_checks++;
      if (led_o !== '0 || tick_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_on_tick led=%0d tick=%0b required led=0 tick=0", led_o, tick_o);
      end
      for (int i = 0; i < 5; i++) tick_clock();
      n_checks++;
      if (led_o !== 4'd5) begin
         n_fail++;
         $display("[TB] FAIL post_reset_count led=%0d required 5", led_o);
      end
      mode = 3'd6;
      tick_clock();
      n_checks++;
      if (led_o !== 4'd5 || tick_o !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL hold_enter led=%0d tick=%0b required led=5 tick=0", led_o, tick_o);
      end
      for (int i = 0; i < 8; i++) begin
         tick_clock();
         n_checks++;
         if (led_o !== 4'd5 || tick_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL hold_step led=%0d tick=%0b required led=5 tick=1", led_o, tick_o);
         end
      end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset = ($urandom_range(63) == 0);
         if ($urandom_range(15) == 0) mode = 3'($urandom_range(7));
         if ($urandom_range(7) == 0) rate_sel = SW'($urandom_range(15));
         enable = ($urandom_range(7) != 0);
         tick_clock();
         n_checks++;
         if (led_o !== m_led || tick_o !== m_tick) begin
            n_fail++;
            $display("[TB] FAIL random_model cyc=%0d mode=%0d led=%0d tick=%0b required led=%0d tick=%0b", cyc, m_mode, led_o, tick_o, m_led, m_tick);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      $display("[TB] led_sequencer bench start");
      test_reset();
      test_up_count();
      test_down_rate();
      test_walk_bounce();
      test_gray();
      test_pause_rate();
      test_reset_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
